// File: rtl/fetch_stage_if.sv
// fetch_stage_if: redirect, instruction-memory and decode handshake bundle; FETCH_STATS_EN adds the stats outputs.
interface fetch_stage_if;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_next;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_stall;
  modport master (
    input  redirect_valid, redirect_pc, imem_instr, id_ready,
    output imem_addr, id_valid, id_instr, id_pc, id_pc_next, stat_fetched, stat_stall
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_instr, id_ready,
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_next, stat_fetched, stat_stall
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, imem_instr, id_ready,
    output imem_addr, id_valid, id_instr, id_pc, id_pc_next
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_instr, id_ready,
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_next
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner feeding a small fetch queue toward decode with redirect support.
// Define FETCH_STATS_EN to add the stat_fetched/stat_stall counters.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter int          QDEPTH   = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QD = CW'(QDEPTH);
  logic [15:0]   pc_q, pc_d;
  logic [15:0]   instr_q [QDEPTH];
  logic [15:0]   epc_q   [QDEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid, pop, push;
  // A redirect voids both the pop and the push of its cycle.
  always_comb begin
    valid   = count_q != '0;
    pop     = valid & bus.id_ready & ~bus.redirect_valid;
    push    = ((count_q < QD) | pop) & ~bus.redirect_valid;
    pc_d    = bus.redirect_valid ? (bus.redirect_pc & 16'hFFFE) : push ? pc_q + PC_STEP : pc_q;
    count_d = bus.redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    rptr_d  = bus.redirect_valid ? '0 : rptr_q + PW'(pop);
    wptr_d  = bus.redirect_valid ? '0 : wptr_q + PW'(push);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wptr_q] <= bus.imem_instr;
      epc_q[wptr_q]   <= pc_q;
    end
  end
  assign bus.imem_addr  = pc_q;
  assign bus.id_valid   = valid;
  assign bus.id_instr   = valid ? instr_q[rptr_q] : '0;
  assign bus.id_pc      = valid ? epc_q[rptr_q] : '0;
  assign bus.id_pc_next = valid ? epc_q[rptr_q] + PC_STEP : '0;
`ifdef FETCH_STATS_EN
  logic [15:0] fetched_q, stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_q + 16'(push);
      stall_q   <= stall_q + 16'(valid & ~bus.id_ready);
    end
  end
  assign bus.stat_fetched = fetched_q;
  assign bus.stat_stall   = stall_q;
`endif
endmodule
